// File: rtl/seg_pkg.sv
// Shared types and constants for the counter display stage.
// Segment patterns are {g,f,e,d,c,b,a}, active-low.
package seg_pkg;

  typedef enum logic [1:0] {
    SHOW_ONES,
    GAP_A,
    SHOW_TENS,
    GAP_B
  } scan_t;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [6:0] SEG_ALL = 7'h00;

  localparam logic [6:0] SEG_D0 = 7'b1000000;
  localparam logic [6:0] SEG_D1 = 7'b1111001;
  localparam logic [6:0] SEG_D2 = 7'b0100100;
  localparam logic [6:0] SEG_D3 = 7'b0110000;
  localparam logic [6:0] SEG_D4 = 7'b0011001;
  localparam logic [6:0] SEG_D5 = 7'b0010010;
  localparam logic [6:0] SEG_D6 = 7'b0000010;
  localparam logic [6:0] SEG_D7 = 7'b1111000;
  localparam logic [6:0] SEG_D8 = 7'b0000000;
  localparam logic [6:0] SEG_D9 = 7'b0010000;

endpackage

// File: rtl/count_seg_driver_dec.sv
// Decimal digit to active-low 7-segment pattern.
// Non-decimal inputs produce a dark digit.
module seg7_dec
  import seg_pkg::*;
(
  input  logic [3:0] d,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    case (d)
      4'd0:    seg = SEG_D0;
      4'd1:    seg = SEG_D1;
      4'd2:    seg = SEG_D2;
      4'd3:    seg = SEG_D3;
      4'd4:    seg = SEG_D4;
      4'd5:    seg = SEG_D5;
      4'd6:    seg = SEG_D6;
      4'd7:    seg = SEG_D7;
      4'd8:    seg = SEG_D8;
      4'd9:    seg = SEG_D9;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/count_seg_driver.sv
// Two-digit multiplexed 7-segment driver for the up/down counter.
// Digit slots are separated by all-off gaps to avoid ghosting.
module count_seg_driver
  import seg_pkg::*;
#(
  parameter int SLOT_CYC = 50000,
  parameter int GAP_CYC  = 500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] ct_in,
  input  logic       ud_in,
  input  logic       upd,
  input  logic       blank_lz,
  input  logic       lamp_test,
  output logic [6:0] seg,
  output logic       dp,
  output logic [1:0] an
);

  localparam int MAXC = (SLOT_CYC > GAP_CYC) ? SLOT_CYC : GAP_CYC;
  localparam int MAXC2 = (MAXC < 2) ? 2 : MAXC;
  localparam int TW = $clog2(MAXC2);
  localparam logic [TW-1:0] SLOT_LAST = TW'(SLOT_CYC - 1);
  localparam logic [TW-1:0] GAP_LAST =
    (GAP_CYC == 0) ? '0 : TW'(GAP_CYC - 1);
  localparam bit NO_GAP = (GAP_CYC == 0);

  scan_t         state, state_nx;
  logic [TW-1:0] timer, timer_nx;
  logic [3:0]    disp_val;
  logic          disp_ud;

  logic          tens;
  logic [3:0]    ones;
  logic [3:0]    dec_in;
  logic [6:0]    dec_seg;

  logic [6:0]    seg_nx;
  logic          dp_nx;
  logic [1:0]    an_nx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= SHOW_ONES;
      timer    <= '0;
      disp_val <= 4'd0;
      disp_ud  <= 1'b1;
      seg      <= SEG_OFF;
      dp       <= 1'b1;
      an       <= 2'b11;
    end else begin
      state <= state_nx;
      timer <= timer_nx;
      if (upd) begin
        disp_val <= ct_in;
        disp_ud  <= ud_in;
      end
      seg <= seg_nx;
      dp  <= dp_nx;
      an  <= an_nx;
    end
  end

  always_comb begin
    state_nx = state;
    timer_nx = timer + 1'b1;
    unique case (state)
      SHOW_ONES: if (timer == SLOT_LAST) begin
        timer_nx = '0;
        state_nx = NO_GAP ? SHOW_TENS : GAP_A;
      end
      GAP_A: if (timer == GAP_LAST) begin
        timer_nx = '0;
        state_nx = SHOW_TENS;
      end
      SHOW_TENS: if (timer == SLOT_LAST) begin
        timer_nx = '0;
        state_nx = NO_GAP ? SHOW_ONES : GAP_B;
      end
      GAP_B: if (timer == GAP_LAST) begin
        timer_nx = '0;
        state_nx = SHOW_ONES;
      end
      default: begin
        timer_nx = '0;
        state_nx = SHOW_ONES;
      end
    endcase
  end

  assign tens   = (disp_val >= 4'd10);
  assign ones   = tens ? (disp_val - 4'd10) : disp_val;
  assign dec_in = (state == SHOW_TENS) ? {3'b000, tens} : ones;

  seg7_dec u_dec (
    .d   (dec_in),
    .seg (dec_seg)
  );

  // Lamp test lights everything in digit slots but never in gaps
  always_comb begin
    seg_nx = SEG_OFF;
    dp_nx  = 1'b1;
    an_nx  = 2'b11;
    unique case (state)
      SHOW_ONES: begin
        an_nx  = 2'b10;
        seg_nx = lamp_test ? SEG_ALL : dec_seg;
        dp_nx  = lamp_test ? 1'b0 : disp_ud;
      end
      SHOW_TENS: begin
        if (lamp_test) begin
          an_nx  = 2'b01;
          seg_nx = SEG_ALL;
          dp_nx  = 1'b0;
        end else if (!(blank_lz && !tens)) begin
          an_nx  = 2'b01;
          seg_nx = dec_seg;
        end
      end
      default: begin
        seg_nx = SEG_OFF;
        dp_nx  = 1'b1;
        an_nx  = 2'b11;
      end
    endcase
  end

endmodule
